// File: rtl/login_pkg.sv
// Shared state encoding, default code geometry and lock-timer sizing for the login authenticator.
// The lockout feature is selected with LOGIN_LOCKOUT_EN in the files that use this package.
package login_pkg;

    typedef enum logic [2:0] {
        COLLECT,
        CHECK,
        GRANTED,
        FAIL,
        LOCKED
    } loginState_t;

    localparam int unsigned DEFAULT_DIGIT_W  = 4;
    localparam int unsigned DEFAULT_CODE_LEN = 4;

    function automatic int unsigned LOCK_CNT_W(input int unsigned lockCycles);
        return (lockCycles > 1) ? $clog2(lockCycles) : 1;
    endfunction

endpackage

// File: rtl/login_lock_timer.sv
// Lockout duration timer: after a start strobe, raises done for one cycle on the LOCK_CYCLES-th cycle.
// Built only when LOGIN_LOCKOUT_EN is defined.
`ifdef LOGIN_LOCKOUT_EN
module login_lock_timer
    import login_pkg::*;
#(
    parameter int unsigned LOCK_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic done
);

    localparam int unsigned CntW = LOCK_CNT_W(LOCK_CYCLES);
    localparam logic [CntW-1:0] LastCnt = CntW'(LOCK_CYCLES - 1);

    logic [CntW-1:0] lockCnt;
    logic            running;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running <= 1'b0;
            lockCnt <= '0;
        end else if (start) begin
            running <= 1'b1;
            lockCnt <= '0;
        end else if (running) begin
            if (lockCnt == LastCnt) begin
                running <= 1'b0;
                lockCnt <= '0;
            end else begin
                lockCnt <= lockCnt + 1'b1;
            end
        end
    end

    assign done = running && (lockCnt == LastCnt);

endmodule
`endif

// File: rtl/login_authenticator.sv
// Digit-code login front end for the difficulty selector; LoggedIn stays high until logout.
// Define LOGIN_LOCKOUT_EN to build the fail counter, LOCKED state and lock timer.
module login_authenticator
    import login_pkg::*;
#(
    parameter int unsigned                   CODE_LEN    = DEFAULT_CODE_LEN,
    parameter int unsigned                   DIGIT_W     = DEFAULT_DIGIT_W,
    parameter logic [CODE_LEN*DIGIT_W-1:0]   PASSWORD    = 16'h1234,
    parameter int unsigned                   MAX_TRIES   = 3,
    parameter int unsigned                   LOCK_CYCLES = 1000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DIGIT_W-1:0]                digit_in,
    input  logic                              digit_valid,
    input  logic                              enter,
    input  logic                              logout,
    output logic                              LoggedIn,
    output logic                              locked,
    output logic                              fail_pulse,
    output logic [$clog2(CODE_LEN+1)-1:0]     digit_count
);

    localparam int unsigned CodeW = CODE_LEN * DIGIT_W;
    localparam int unsigned CntW  = $clog2(CODE_LEN + 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(CODE_LEN);

    loginState_t      state, nextState;
    logic [CodeW-1:0] codeBuf;
    logic [CntW-1:0]  digitCnt;
    logic             match;
    logic             lastTry;
    logic             lockDone;

    assign match = (digitCnt == FullCnt) && (codeBuf == PASSWORD);

`ifdef LOGIN_LOCKOUT_EN
    localparam int unsigned FailW = $clog2(MAX_TRIES + 1);

    logic [FailW-1:0] failCnt;
    logic             lockStart;

    assign lastTry   = (failCnt + 1'b1) == FailW'(MAX_TRIES);
    assign lockStart = (state == FAIL) && lastTry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            failCnt <= '0;
        end else if (state == CHECK && match) begin
            failCnt <= '0;
        end else if (state == FAIL) begin
            failCnt <= failCnt + 1'b1;
        end else if (state == LOCKED && lockDone) begin
            failCnt <= '0;
        end
    end

    login_lock_timer #(
        .LOCK_CYCLES(LOCK_CYCLES)
    ) lockTimer (
        .clk  (clk),
        .rst  (rst),
        .start(lockStart),
        .done (lockDone)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked <= 1'b0;
        end else begin
            locked <= (state == LOCKED);
        end
    end
`else
    logic unusedLockCfg;

    assign unusedLockCfg = ^{MAX_TRIES, LOCK_CYCLES};
    assign lastTry       = 1'b0;
    assign lockDone      = 1'b0;
    assign locked        = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            COLLECT: if (enter)    nextState = CHECK;
            CHECK:   nextState = match ? GRANTED : FAIL;
            GRANTED: if (logout)   nextState = COLLECT;
            FAIL:    nextState = lastTry ? LOCKED : COLLECT;
            LOCKED:  if (lockDone) nextState = COLLECT;
            default: nextState = COLLECT;
        endcase
    end

    // enter wins over a simultaneous digit; digits beyond CODE_LEN are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            codeBuf  <= '0;
            digitCnt <= '0;
        end else if (state != COLLECT && nextState == COLLECT) begin
            codeBuf  <= '0;
            digitCnt <= '0;
        end else if (state == COLLECT && digit_valid && !enter && digitCnt != FullCnt) begin
            codeBuf  <= (codeBuf << DIGIT_W) | CodeW'(digit_in);
            digitCnt <= digitCnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            LoggedIn   <= 1'b0;
            fail_pulse <= 1'b0;
        end else begin
            LoggedIn   <= (state == GRANTED);
            fail_pulse <= (state == FAIL);
        end
    end

    assign digit_count = digitCnt;

endmodule

// File: tb/tb_login_authenticator.sv
// Randomized self-checking bench for login_authenticator against a transaction-level model.
// Expectations follow LOGIN_LOCKOUT_EN as defined for the build.
module tb_login_authenticator;

    localparam int unsigned CodeLen    = 4;
    localparam int unsigned DigitW     = 4;
    localparam int unsigned MaxTries   = 3;
    localparam int unsigned LockCycles = 20;
    localparam logic [15:0] Password   = 16'h1234;

`ifdef LOGIN_LOCKOUT_EN
    localparam bit LockoutEn = 1'b1;
`else
    localparam bit LockoutEn = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [DigitW-1:0] digitIn;
    logic              digitValid;
    logic              enter;
    logic              logout;
    logic              LoggedIn;
    logic              locked;
    logic              failPulse;
    logic [2:0]        digitCount;

    login_authenticator #(
        .CODE_LEN   (CodeLen),
        .DIGIT_W    (DigitW),
        .PASSWORD   (Password),
        .MAX_TRIES  (MaxTries),
        .LOCK_CYCLES(LockCycles)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digit_in   (digitIn),
        .digit_valid(digitValid),
        .enter      (enter),
        .logout     (logout),
        .LoggedIn   (LoggedIn),
        .locked     (locked),
        .fail_pulse (failPulse),
        .digit_count(digitCount)
    );

    always #5 clk = ~clk;

    int unsigned testsRun    = 0;
    int unsigned testsFailed = 0;

    // Reference model: digits collected so far, session flag, consecutive failures.
    int unsigned entered[$];
    bit          loggedIn;
    int unsigned fails;
    int unsigned pw[CodeLen];

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic bit codeMatches();
        if (entered.size() != CodeLen) return 1'b0;
        for (int unsigned i = 0; i < CodeLen; i++)
            if (entered[i] != pw[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic sendDigit(input int unsigned d);
        digitIn    = DigitW'(d);
        digitValid = 1'b1;
        step();
        digitValid = 1'b0;
        if (!loggedIn && entered.size() < CodeLen) entered.push_back(d);
        checkVal("digitCount", 32'(digitCount), 32'(entered.size()));
        checkVal("sessionHold", 32'(LoggedIn), 32'(loggedIn));
        checkVal("noFailPulse", 32'(failPulse), 0);
        checkVal("notLocked", 32'(locked), 0);
    endtask

    task automatic sendSeq(input logic [31:0] digits, input int unsigned n);
        for (int unsigned i = 0; i < n; i++)
            sendDigit(32'((digits >> (4 * (n - 1 - i))) & 32'hF));
    endtask

    task automatic waitLockout();
        int unsigned highCycles = 0;
        for (int unsigned i = 1; i <= LockCycles + 1; i++) begin
            // replay the correct code while locked; none of it may count
            if (i <= LockCycles) begin
                if (i % 5 == 0) begin
                    enter = 1'b1;
                end else begin
                    digitValid = 1'b1;
                    digitIn    = DigitW'(pw[(i % 5) - 1]);
                end
            end
            step();
            enter      = 1'b0;
            digitValid = 1'b0;
            if (locked) highCycles++;
            checkVal("lockedWindow", 32'(locked), 32'(i <= LockCycles));
        end
        checkVal("lockedLength", highCycles, LockCycles);
        checkVal("noGrantInLock", 32'(LoggedIn), 0);
        checkVal("countAfterLock", 32'(digitCount), 0);
    endtask

    task automatic submit(input bit withDigit, input int unsigned d);
        bit match;
        enter      = 1'b1;
        digitValid = withDigit;
        digitIn    = DigitW'(d);
        step();
        enter      = 1'b0;
        digitValid = 1'b0;
        step();
        step();
        if (loggedIn) begin
            checkVal("grantedIgnoresEnter", 32'(LoggedIn), 1);
            checkVal("noFailWhileGranted", 32'(failPulse), 0);
            checkVal("countWhileGranted", 32'(digitCount), 32'(entered.size()));
        end else begin
            match = codeMatches();
            checkVal("grantAfterEnter", 32'(LoggedIn), 32'(match));
            checkVal("failPulse", 32'(failPulse), 32'(!match));
            checkVal("lockedAfterEnter", 32'(locked), 0);
            if (match) begin
                loggedIn = 1'b1;
                fails    = 0;
                checkVal("countAtGrant", 32'(digitCount), CodeLen);
            end else begin
                entered.delete();
                fails++;
                checkVal("countClearedOnFail", 32'(digitCount), 0);
                if (LockoutEn && fails == MaxTries) begin
                    waitLockout();
                    fails = 0;
                end
            end
        end
    endtask

    task automatic logoutOp();
        logout = 1'b1;
        step();
        logout = 1'b0;
        if (loggedIn) begin
            checkVal("logoutLag", 32'(LoggedIn), 1);
            step();
            checkVal("loggedOut", 32'(LoggedIn), 0);
            loggedIn = 1'b0;
            entered.delete();
            checkVal("countAfterLogout", 32'(digitCount), 0);
        end else begin
            checkVal("logoutIgnored", 32'(LoggedIn), 0);
            checkVal("countKeptOnLogout", 32'(digitCount), 32'(entered.size()));
        end
    endtask

    task automatic resetOp(input bit viaCheck);
        if (viaCheck) begin
            enter = 1'b1;
            step();
            enter = 1'b0;
        end
        #1 rst = 1'b1;
        #1;
        checkVal("rstLoggedIn", 32'(LoggedIn), 0);
        checkVal("rstFailPulse", 32'(failPulse), 0);
        checkVal("rstLocked", 32'(locked), 0);
        checkVal("rstCount", 32'(digitCount), 0);
        #1 rst = 1'b0;
        step();
        entered.delete();
        loggedIn = 1'b0;
        fails    = 0;
        checkVal("postRstCount", 32'(digitCount), 0);
    endtask

    task automatic randomAttempt();
        int unsigned len = $urandom_range(3, 5);
        for (int unsigned j = 0; j < len; j++) begin
            if (j < CodeLen && $urandom_range(0, 3) != 0) sendDigit(pw[j]);
            else sendDigit($urandom_range(0, 15));
        end
        submit($urandom_range(0, 7) == 0, $urandom_range(0, 15));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed + 1);
        $fatal(1);
    end

    initial begin
        for (int unsigned i = 0; i < CodeLen; i++)
            pw[i] = 32'((Password >> (DigitW * (CodeLen - 1 - i))) & 16'h000F);
        rst        = 1'b1;
        digitIn    = '0;
        digitValid = 1'b0;
        enter      = 1'b0;
        logout     = 1'b0;
        loggedIn   = 1'b0;
        fails      = 0;
        step();
        step();
        checkVal("resetLoggedIn", 32'(LoggedIn), 0);
        checkVal("resetLocked", 32'(locked), 0);
        checkVal("resetFailPulse", 32'(failPulse), 0);
        checkVal("resetCount", 32'(digitCount), 0);
        #1 rst = 1'b0;
        step();

        // correct code, strobes ignored while granted, logout
        sendSeq(32'h1234, 4);
        submit(1'b0, 0);
        sendDigit(9);
        submit(1'b1, 5);
        logoutOp();

        // wrong code, then grant; a cleared fail counter survives two more misses
        sendSeq(32'h1235, 4);
        submit(1'b0, 0);
        sendSeq(32'h1234, 4);
        submit(1'b0, 0);
        logoutOp();
        sendSeq(32'h9999, 4);
        submit(1'b0, 0);
        sendSeq(32'h1243, 4);
        submit(1'b0, 0);
        sendSeq(32'h1234, 4);
        submit(1'b0, 0);
        logoutOp();

        // three misses in a row, then the same correct code afterwards
        for (int unsigned k = 0; k < MaxTries; k++) begin
            sendSeq(32'h4321, 4);
            submit(1'b0, 0);
        end
        sendSeq(32'h1234, 4);
        submit(1'b0, 0);
        logoutOp();

        // length boundaries and enter racing a digit
        sendSeq(32'h123, 3);
        submit(1'b0, 0);
        sendSeq(32'h12349, 5);
        submit(1'b0, 0);
        logoutOp();
        sendSeq(32'h123, 3);
        submit(1'b1, 4);

        // asynchronous reset mid-CHECK and while granted
        sendSeq(32'h1234, 4);
        resetOp(1'b1);
        sendSeq(32'h1234, 4);
        submit(1'b0, 0);
        resetOp(1'b0);

        for (int unsigned n = 0; n < 300; n++) begin
            int unsigned op = $urandom_range(0, 19);
            if (op < 10)       randomAttempt();
            else if (op < 13)  sendDigit($urandom_range(0, 15));
            else if (op < 15)  submit($urandom_range(0, 3) == 0, $urandom_range(0, 15));
            else if (op < 18)  logoutOp();
            else               resetOp(op == 18);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
